// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: ID/EX source and destination fields in, stall/flush controls out.
// The hazard unit connects through the slave modport; the pipeline (or a bench) drives through master.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_MemRead;
    logic [4:0]  ex_rt;
    logic        id_branch_taken;
    logic        id_jump;
    logic        ex_md_start;
    logic        id_hilo_use;
    logic        pc_wr_en;
    logic        if_id_wr_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        md_busy;
    logic [15:0] stall_cycles;

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
        input  id_branch_taken, id_jump, ex_md_start, id_hilo_use,
        output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, md_busy, stall_cycles
    );

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
        output id_branch_taken, id_jump, ex_md_start, id_hilo_use,
        input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use and HI/LO-busy stalls, redirect flush, saturating stall-cycle counter.
// Latency: controls are combinational from ID/EX fields; md_busy/stall_cycles are registered.
// Backpressure: a stall freezes PC and IF/ID and bubbles EX; HI/LO interlock only with HAZARD_MD_INTERLOCK_EN.
module hazard_ctrl #(
    parameter int MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);

    logic        load_use;
    logic        md_stall;
    logic        md_busy;
    logic        stall;
    logic        redirect;
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;

    // Writes to $zero are discarded, so a load into r0 never creates a dependency.
    always_comb begin
        load_use = hz.ex_MemRead && (hz.ex_rt != 5'd0) &&
                   ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    end

`ifdef HAZARD_MD_INTERLOCK_EN
    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    md_state_e  state_q;
    md_state_e  state_d;
    logic [5:0] md_cnt_q;
    logic [5:0] md_cnt_d;

    // A start arriving while busy is dropped; the running count is never reloaded.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (hz.ex_md_start) begin
                    md_cnt_d = 6'(MD_LATENCY);
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - 6'd1;
                if (md_cnt_q == 6'd1) begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d  = MD_IDLE;
                md_cnt_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy  = (md_cnt_q != 6'd0);
    assign md_stall = md_busy && hz.id_hilo_use;
`else
    logic unused_md;

    assign unused_md = ^{hz.ex_md_start, hz.id_hilo_use, 6'(MD_LATENCY)};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

    assign stall    = load_use || md_stall;
    assign redirect = hz.id_branch_taken || hz.id_jump;

    // The stalled instruction in ID must survive, so a stall masks any redirect flush.
    always_comb begin
        hz.pc_wr_en    = !stall;
        hz.if_id_wr_en = !stall;
        hz.id_ex_flush = stall;
        hz.if_id_flush = redirect && !stall;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.md_busy      = md_busy;
    assign hz.stall_cycles = stall_cycles_q;

endmodule
